// File: rtl/accumulator_adder_tree.sv
// Pipelined, flag-controlled binary reduction of NUM_INPUTS signed partial sums,
// followed by an optional running accumulation with saturating or wrapping output.
module accumulator_adder_tree #(
   parameter int NUM_INPUTS = 4,
   parameter int IN_WIDTH   = 28,
   parameter int OUT_WIDTH  = 32,
   parameter int SATURATE   = 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             valid_i,
   input  logic [NUM_INPUTS-2:0]            adders_flag_i,
   input  logic                             acc_mode_i,
   input  logic [NUM_INPUTS*IN_WIDTH-1:0]   accumulator_i,
   output logic signed [OUT_WIDTH-1:0]      accumulator_o,
   output logic                             valid_o,
   output logic                             sat_o
);

   localparam int LEVELS = $clog2(NUM_INPUTS);
   localparam int TREE_W = IN_WIDTH + LEVELS;
   localparam int SUM_W  = ((OUT_WIDTH > TREE_W) ? OUT_WIDTH : TREE_W) + 2;

   localparam logic signed [SUM_W-1:0] MAX_V =
      {{(SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] MIN_V =
      {{(SUM_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   // Handshake: valid-only, no backpressure. A beat is accepted on every rising edge
   // where valid_i=1; each stage loads only on its incoming valid and otherwise holds.
   // valid_o pulses for exactly one cycle when accumulator_o takes a new result.
   for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
      localparam int NODES = NUM_INPUTS >> (l + 1);
      localparam int WI    = IN_WIDTH + l;
      localparam int WO    = WI + 1;
      localparam int FW    = (NUM_INPUTS >> l) - 1;

      logic [2*NODES*WI-1:0] din;
      logic [FW-1:0]         flags;
      logic                  vin;
      logic                  mode_in;
      logic [NODES*WO-1:0]   sum;
      logic [NODES*WO-1:0]   data_q;
      logic                  vld_q;
      logic                  mode_q;

      if (l == 0) begin : g_src
         assign din     = accumulator_i;
         assign flags   = adders_flag_i;
         assign vin     = valid_i;
         assign mode_in = acc_mode_i;
      end else begin : g_src
         assign din     = g_lvl[l-1].data_q;
         assign flags   = g_lvl[l-1].g_fwd.fwd_q;
         assign vin     = g_lvl[l-1].vld_q;
         assign mode_in = g_lvl[l-1].mode_q;
      end

      // The low NODES flag bits belong to this level; the rest ride along with the beat.
      for (genvar k = 0; k < NODES; k++) begin : g_node
         logic signed [WI-1:0] left;
         logic signed [WI-1:0] right;
         assign left  = din[2*k*WI +: WI];
         assign right = din[(2*k+1)*WI +: WI];
         assign sum[k*WO +: WO] = flags[k] ? ({left[WI-1], left} + {right[WI-1], right})
                                           : {left[WI-1], left};
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            vld_q  <= 1'b0;
            mode_q <= 1'b0;
            data_q <= '0;
         end else begin
            vld_q <= vin;
            if (vin) begin
               data_q <= sum;
               mode_q <= mode_in;
            end
         end
      end

      if (l < LEVELS - 1) begin : g_fwd
         logic [FW-NODES-1:0] fwd_q;
         always_ff @(posedge clk) begin
            if (reset) begin
               fwd_q <= '0;
            end else if (vin) begin
               fwd_q <= flags[FW-1:NODES];
            end
         end
      end
   end

   logic signed [TREE_W-1:0] tree;
   logic                     tree_vld;
   logic                     tree_mode;
   logic signed [SUM_W-1:0]  tree_ext;
   logic signed [SUM_W-1:0]  addend;
   logic signed [SUM_W-1:0]  total;
   logic signed [OUT_WIDTH-1:0] result;
   logic                     clamped;

   assign tree      = g_lvl[LEVELS-1].data_q;
   assign tree_vld  = g_lvl[LEVELS-1].vld_q;
   assign tree_mode = g_lvl[LEVELS-1].mode_q;

   // Running accumulator and output are the same register, so back-to-back
   // accumulate beats always see the previous beat's result.
   always_comb begin
      tree_ext = SUM_W'(tree);
      addend   = '0;
      if (tree_mode) begin
         addend = SUM_W'(accumulator_o);
      end
      total   = tree_ext + addend;
      result  = total[OUT_WIDTH-1:0];
      clamped = 1'b0;
      if (SATURATE != 0) begin
         if (total > MAX_V) begin
            result  = MAX_V[OUT_WIDTH-1:0];
            clamped = 1'b1;
         end else if (total < MIN_V) begin
            result  = MIN_V[OUT_WIDTH-1:0];
            clamped = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         accumulator_o <= '0;
         valid_o       <= 1'b0;
         sat_o         <= 1'b0;
      end else begin
         valid_o <= tree_vld;
         sat_o   <= tree_vld & clamped;
         if (tree_vld) begin
            accumulator_o <= result;
         end
      end
   end

endmodule

// File: tb/tb_accumulator_adder_tree.sv
// Directed bench for accumulator_adder_tree: default N=4 instance, two 24-bit output
// instances (saturating and wrapping), and an N=8 instance for per-beat flag carriage.
module tb_accumulator_adder_tree;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // N=4, IN=28, OUT=32, saturating
   logic         a_valid, a_mode, a_vo, a_sat;
   logic [2:0]   a_flags;
   logic [111:0] a_in;
   logic [31:0]  a_out;

   // N=4, IN=24, OUT=24; shared stimulus, SATURATE=1 and SATURATE=0
   logic         sw_valid, sw_mode;
   logic [2:0]   sw_flags;
   logic [95:0]  sw_in;
   logic [23:0]  s_out, w_out;
   logic         s_vo, s_sat, w_vo, w_sat;

   // N=8, IN=28, OUT=32
   logic         e_valid, e_mode, e_vo, e_sat;
   logic [6:0]   e_flags;
   logic [223:0] e_in;
   logic [31:0]  e_out;

   accumulator_adder_tree #(.NUM_INPUTS(4), .IN_WIDTH(28), .OUT_WIDTH(32), .SATURATE(1)) u_a (
      .clk(clk), .reset(reset), .valid_i(a_valid), .adders_flag_i(a_flags),
      .acc_mode_i(a_mode), .accumulator_i(a_in), .accumulator_o(a_out),
      .valid_o(a_vo), .sat_o(a_sat));

   accumulator_adder_tree #(.NUM_INPUTS(4), .IN_WIDTH(24), .OUT_WIDTH(24), .SATURATE(1)) u_s (
      .clk(clk), .reset(reset), .valid_i(sw_valid), .adders_flag_i(sw_flags),
      .acc_mode_i(sw_mode), .accumulator_i(sw_in), .accumulator_o(s_out),
      .valid_o(s_vo), .sat_o(s_sat));

   accumulator_adder_tree #(.NUM_INPUTS(4), .IN_WIDTH(24), .OUT_WIDTH(24), .SATURATE(0)) u_w (
      .clk(clk), .reset(reset), .valid_i(sw_valid), .adders_flag_i(sw_flags),
      .acc_mode_i(sw_mode), .accumulator_i(sw_in), .accumulator_o(w_out),
      .valid_o(w_vo), .sat_o(w_sat));

   accumulator_adder_tree #(.NUM_INPUTS(8), .IN_WIDTH(28), .OUT_WIDTH(32), .SATURATE(1)) u_e (
      .clk(clk), .reset(reset), .valid_i(e_valid), .adders_flag_i(e_flags),
      .acc_mode_i(e_mode), .accumulator_i(e_in), .accumulator_o(e_out),
      .valid_o(e_vo), .sat_o(e_sat));

   function automatic logic [111:0] pack28(input int x0, input int x1, input int x2, input int x3);
      return {28'(x3), 28'(x2), 28'(x1), 28'(x0)};
   endfunction

   function automatic logic [95:0] pack24(input int x0, input int x1, input int x2, input int x3);
      return {24'(x3), 24'(x2), 24'(x1), 24'(x0)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset = 1'b1;
      a_valid = 1'b0; a_mode = 1'b0; a_flags = '0; a_in = '0;
      sw_valid = 1'b0; sw_mode = 1'b0; sw_flags = '0; sw_in = '0;
      e_valid = 1'b0; e_mode = 1'b0; e_flags = '0; e_in = '0;

      repeat (3) @(negedge clk);
      check("rst_vo", {31'd0, a_vo}, 32'd0);
      check("rst_out", a_out, 32'd0);
      check("rst_sat", {31'd0, a_sat}, 32'd0);
      check("rst_e_vo", {31'd0, e_vo}, 32'd0);
      reset = 1'b0;

      // all adders on: 1+2+3+4
      @(negedge clk);
      a_valid = 1'b1; a_flags = 3'b111; a_mode = 1'b0; a_in = pack28(1, 2, 3, 4);
      @(negedge clk);
      a_valid = 1'b0; a_in = '0;
      check("t1_lat1", {31'd0, a_vo}, 32'd0);
      @(negedge clk);
      check("t1_lat2", {31'd0, a_vo}, 32'd0);
      @(negedge clk);
      check("t1_vo", {31'd0, a_vo}, 32'd1);
      check("t1_out", a_out, 32'd10);
      check("t1_sat", {31'd0, a_sat}, 32'd0);
      @(negedge clk);
      check("t1_pulse", {31'd0, a_vo}, 32'd0);
      check("t1_hold", a_out, 32'd10);

      // node0 drops its right input: 5 + (-3+2) = 4; flags change while in flight
      @(negedge clk);
      a_valid = 1'b1; a_flags = 3'b110; a_in = pack28(5, 7, -3, 2);
      @(negedge clk);
      a_valid = 1'b0; a_flags = 3'b111; a_in = '0;
      @(negedge clk);
      @(negedge clk);
      check("t2_vo", {31'd0, a_vo}, 32'd1);
      check("t2_out", a_out, 32'd4);

      // back-to-back 10, 20, 30 with restart, accumulate, accumulate
      @(negedge clk);
      a_valid = 1'b1; a_flags = 3'b111; a_mode = 1'b0; a_in = pack28(1, 2, 3, 4);
      @(negedge clk);
      a_mode = 1'b1; a_in = pack28(5, 5, 5, 5);
      @(negedge clk);
      a_mode = 1'b1; a_in = pack28(10, 10, 5, 5);
      @(negedge clk);
      a_valid = 1'b0; a_mode = 1'b0; a_in = '0;
      check("t3_vo0", {31'd0, a_vo}, 32'd1);
      check("t3_out0", a_out, 32'd10);
      @(negedge clk);
      check("t3_vo1", {31'd0, a_vo}, 32'd1);
      check("t3_out1", a_out, 32'd30);
      @(negedge clk);
      check("t3_vo2", {31'd0, a_vo}, 32'd1);
      check("t3_out2", a_out, 32'd60);
      @(negedge clk);
      check("t3_end_vo", {31'd0, a_vo}, 32'd0);
      check("t3_end_out", a_out, 32'd60);

      // reset one cycle after a beat discards it and clears the accumulator
      @(negedge clk);
      a_valid = 1'b1; a_mode = 1'b0; a_in = pack28(40, 30, 20, 9);
      @(negedge clk);
      a_valid = 1'b0; a_in = '0; reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("t5_rst_out", a_out, 32'd0);
      check("t5_rst_vo", {31'd0, a_vo}, 32'd0);
      @(negedge clk);
      check("t5_drop_vo0", {31'd0, a_vo}, 32'd0);
      @(negedge clk);
      check("t5_drop_vo1", {31'd0, a_vo}, 32'd0);
      check("t5_drop_out", a_out, 32'd0);
      @(negedge clk);
      a_valid = 1'b1; a_mode = 1'b1; a_in = pack28(3, 4, 0, 0);
      @(negedge clk);
      a_valid = 1'b0; a_mode = 1'b0; a_in = '0;
      @(negedge clk);
      @(negedge clk);
      check("t5_vo", {31'd0, a_vo}, 32'd1);
      check("t5_out", a_out, 32'd7);

      // 24-bit output: +2^23, then +1 onto it, then -2^24
      @(negedge clk);
      sw_valid = 1'b1; sw_flags = 3'b111; sw_mode = 1'b0; sw_in = pack24(4194304, 4194304, 0, 0);
      @(negedge clk);
      sw_mode = 1'b1; sw_in = pack24(1, 0, 0, 0);
      @(negedge clk);
      sw_mode = 1'b0; sw_in = pack24(-8388608, -8388608, 0, 0);
      @(negedge clk);
      sw_valid = 1'b0; sw_in = '0;
      check("t4_s_vo", {31'd0, s_vo}, 32'd1);
      check("t4_s_pos_out", {8'd0, s_out}, 32'h007fffff);
      check("t4_s_pos_sat", {31'd0, s_sat}, 32'd1);
      check("t4_w_vo", {31'd0, w_vo}, 32'd1);
      check("t4_w_pos_out", {8'd0, w_out}, 32'h00800000);
      check("t4_w_pos_sat", {31'd0, w_sat}, 32'd0);
      @(negedge clk);
      check("t4_s_acc_out", {8'd0, s_out}, 32'h007fffff);
      check("t4_s_acc_sat", {31'd0, s_sat}, 32'd1);
      check("t4_w_acc_out", {8'd0, w_out}, 32'h00800001);
      check("t4_w_acc_sat", {31'd0, w_sat}, 32'd0);
      @(negedge clk);
      check("t4_s_neg_out", {8'd0, s_out}, 32'h00800000);
      check("t4_s_neg_sat", {31'd0, s_sat}, 32'd1);
      check("t4_w_neg_out", {8'd0, w_out}, 32'h00000000);
      check("t4_w_neg_sat", {31'd0, w_sat}, 32'd0);
      @(negedge clk);
      check("t4_s_idle_sat", {31'd0, s_sat}, 32'd0);
      check("t4_s_hold", {8'd0, s_out}, 32'h00800000);

      // N=8, inputs 3,-5,10,7,-20,4,100,-1 with flags changing every beat
      @(negedge clk);
      e_in = {28'(-1), 28'(100), 28'(4), 28'(-20), 28'(7), 28'(10), 28'(-5), 28'(3)};
      e_valid = 1'b1; e_mode = 1'b0; e_flags = 7'h7f;
      @(negedge clk);
      e_flags = 7'h00;
      @(negedge clk);
      e_flags = 7'h55;
      @(negedge clk);
      e_flags = 7'h6a;
      @(negedge clk);
      e_flags = 7'h7f; e_mode = 1'b1;
      check("t6_vo_a", {31'd0, e_vo}, 32'd1);
      check("t6_out_a", e_out, 32'd98);
      @(negedge clk);
      e_valid = 1'b0; e_mode = 1'b0; e_flags = 7'h00;
      check("t6_out_b", e_out, 32'd3);
      @(negedge clk);
      check("t6_out_c", e_out, 32'hfffffff8);
      @(negedge clk);
      check("t6_out_d", e_out, 32'd82);
      @(negedge clk);
      check("t6_vo_e", {31'd0, e_vo}, 32'd1);
      check("t6_out_e", e_out, 32'd180);
      @(negedge clk);
      check("t6_end_vo", {31'd0, e_vo}, 32'd0);
      check("t6_end_sat", {31'd0, e_sat}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
